spi_apb_seq: RTL and testbench

APB master sequencer that drives the SPI register block's APB slave port on behalf of a simple byte-stream client. It programs CR2, BR and CR1 from configuration inputs, then runs one SPI exchange per command byte: write DR, poll SR until SPIF, read DR, return the received byte. It sits between the system/DMA side and the SPI APB interface, and is the only APB master on that port.

---
 rtl/spi_apb_pkg.sv | 34 +++
 rtl/spi_apb_seq_xfer.sv | 97 +++++++++
 rtl/spi_apb_seq.sv | 269 ++++++++++++++++++++++++++
 tb/tb_spi_apb_seq.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_apb_pkg.sv
// Shared definitions for the SPI APB sequencer: register map, SR bit
// positions and the state encodings of the sequencer and transfer engine.
package spi_apb_pkg;

  localparam logic [2:0] ADDR_CR1 = 3'd0;
  localparam logic [2:0] ADDR_CR2 = 3'd1;
  localparam logic [2:0] ADDR_BR  = 3'd2;
  localparam logic [2:0] ADDR_SR  = 3'd3;
  localparam logic [2:0] ADDR_DR  = 3'd5;

  localparam int unsigned SR_SPIF  = 7;
  localparam int unsigned SR_SPTEF = 5;
  localparam int unsigned SR_MODF  = 4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CFG_CR2,
    ST_CFG_BR,
    ST_CFG_CR1,
    ST_READY,
    ST_WR_DR,
    ST_POLL_SR,
    ST_RD_DR,
    ST_RESP
  } seq_state_e;

  typedef enum logic [1:0] {
    X_IDLE,
    X_SETUP,
    X_ACCESS,
    X_GAP
  } xfer_state_e;

endpackage

// File: rtl/spi_apb_seq_xfer.sv
// Single-transfer APB master engine. A request seen in IDLE or in the
// one-cycle post-transfer gap launches SETUP next cycle; address, direction
// and write data are latched at launch and held until the transfer completes.
module spi_apb_seq_xfer
  import spi_apb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] addr,
  input  logic       write,
  input  logic [7:0] wdata,
  output logic       done,
  output logic [7:0] rdata,
  output logic       slverr,
  output logic [2:0] P_addr,
  output logic       P_sel,
  output logic       P_enable,
  output logic       P_write,
  output logic [7:0] P_wdata,
  input  logic       P_ready,
  input  logic       P_slverr,
  input  logic [7:0] P_rdata
);

  xfer_state_e state_q, state_d;
  logic        sel_q, sel_d;
  logic        en_q, en_d;
  logic [2:0]  addr_q, addr_d;
  logic        write_q, write_d;
  logic [7:0]  wdata_q, wdata_d;

  // Next-state logic for the SETUP / ACCESS / GAP sequence.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    en_d    = en_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    case (state_q)
      X_IDLE, X_GAP: begin
        if (start) begin
          state_d = X_SETUP;
          sel_d   = 1'b1;
          en_d    = 1'b0;
          addr_d  = addr;
          write_d = write;
          wdata_d = wdata;
        end else begin
          state_d = X_IDLE;
        end
      end
      X_SETUP: begin
        state_d = X_ACCESS;
        en_d    = 1'b1;
      end
      X_ACCESS: begin
        if (P_ready) begin
          state_d = X_GAP;
          sel_d   = 1'b0;
          en_d    = 1'b0;
        end
      end
      default: state_d = X_IDLE;
    endcase
  end

  // Engine state and registered APB pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= X_IDLE;
      sel_q   <= 1'b0;
      en_q    <= 1'b0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
    end
  end

  assign done     = en_q & P_ready;
  assign rdata    = P_rdata;
  assign slverr   = en_q & P_ready & P_slverr;
  assign P_addr   = addr_q;
  assign P_sel    = sel_q;
  assign P_enable = en_q;
  assign P_write  = write_q;
  assign P_wdata  = wdata_q;

endmodule

// File: rtl/spi_apb_seq.sv
// APB master sequencer for the SPI register block: programs CR2, BR, CR1,
// then runs write-DR / poll-SR / read-DR per command byte.
// Optional build macro SPI_SEQ_IRQ_WAIT_EN: wait for spi_interrupt_request
// instead of continuous SR polling, confirming SPIF with one SR read.
module spi_apb_seq
  import spi_apb_pkg::*;
#(
  parameter int unsigned POLL_LIMIT = 255
) (
  input  logic       P_clk,
  input  logic       P_rst,
  output logic [2:0] P_addr,
  output logic       P_sel,
  output logic       P_enable,
  output logic       P_write,
  output logic [7:0] P_wdata,
  input  logic       P_ready,
  input  logic       P_slverr,
  input  logic [7:0] P_rdata,
  input  logic       spi_interrupt_request,
  input  logic [7:0] cfg_cr1,
  input  logic [7:0] cfg_cr2,
  input  logic [7:0] cfg_br,
  input  logic       cfg_start,
  output logic       cfg_done,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       busy
);

  localparam logic [7:0] LIMIT = 8'(POLL_LIMIT);

  seq_state_e state_q, state_d;
  logic [7:0] cr1_q, cr1_d, cr2_q, cr2_d, br_q, br_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] cnt_q, cnt_d, cnt_inc;
  logic       cfg_done_q, cfg_done_d;
  logic       rdy_q, rdy_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       rsp_err_q, rsp_err_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       busy_q, busy_d;

  logic       req;
  logic [2:0] req_addr;
  logic       req_write;
  logic [7:0] req_wdata;
  logic       x_done;
  logic       x_slverr;
  logic [7:0] x_rdata;

`ifdef SPI_SEQ_IRQ_WAIT_EN
  logic       irq_rd_q, irq_rd_d;
`else
  logic       unused_irq;
  assign unused_irq = spi_interrupt_request;
`endif

  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  // Sequencing: request one APB transfer per state and advance on completion.
  always_comb begin
    state_d    = state_q;
    cr1_d      = cr1_q;
    cr2_d      = cr2_q;
    br_d       = br_q;
    cmd_d      = cmd_q;
    cnt_d      = cnt_q;
    cfg_done_d = cfg_done_q;
    rsp_err_d  = rsp_err_q;
    rsp_data_d = rsp_data_q;
    req        = 1'b0;
    req_addr   = ADDR_CR1;
    req_write  = 1'b0;
    req_wdata  = '0;
`ifdef SPI_SEQ_IRQ_WAIT_EN
    irq_rd_d   = irq_rd_q;
`endif
    case (state_q)
      ST_IDLE, ST_READY: begin
        if (cfg_start) begin
          cr1_d      = cfg_cr1;
          cr2_d      = cfg_cr2;
          br_d       = cfg_br;
          cfg_done_d = 1'b0;
          state_d    = ST_CFG_CR2;
        end else if (state_q == ST_READY && cmd_valid) begin
          cmd_d   = cmd_data;
          state_d = ST_WR_DR;
        end
      end
      ST_CFG_CR2: begin
        req       = 1'b1;
        req_addr  = ADDR_CR2;
        req_write = 1'b1;
        req_wdata = cr2_q;
        if (x_done) state_d = ST_CFG_BR;
      end
      ST_CFG_BR: begin
        req       = 1'b1;
        req_addr  = ADDR_BR;
        req_write = 1'b1;
        req_wdata = br_q;
        if (x_done) state_d = ST_CFG_CR1;
      end
      ST_CFG_CR1: begin
        req       = 1'b1;
        req_addr  = ADDR_CR1;
        req_write = 1'b1;
        req_wdata = cr1_q;
        if (x_done) begin
          cfg_done_d = 1'b1;
          state_d    = ST_READY;
        end
      end
      ST_WR_DR: begin
        req       = 1'b1;
        req_addr  = ADDR_DR;
        req_write = 1'b1;
        req_wdata = cmd_q;
        if (x_done) begin
          if (x_slverr) begin
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
            state_d    = ST_RESP;
          end else begin
            cnt_d   = '0;
`ifdef SPI_SEQ_IRQ_WAIT_EN
            irq_rd_d = 1'b0;
`endif
            state_d = ST_POLL_SR;
          end
        end
      end
      ST_POLL_SR: begin
`ifdef SPI_SEQ_IRQ_WAIT_EN
        // Waiting sub-phase issues no APB traffic; irq_rd_q marks the
        // single confirming SR read.
        if (irq_rd_q) begin
          req      = 1'b1;
          req_addr = ADDR_SR;
          if (x_done) begin
            irq_rd_d = 1'b0;
            if (x_slverr) begin
              rsp_err_d  = 1'b1;
              rsp_data_d = '0;
              state_d    = ST_RESP;
            end else if (x_rdata[SR_SPIF]) begin
              state_d = ST_RD_DR;
            end
          end
        end else if (spi_interrupt_request) begin
          irq_rd_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= LIMIT) begin
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
            state_d    = ST_RESP;
          end
        end
`else
        req      = 1'b1;
        req_addr = ADDR_SR;
        if (x_done) begin
          if (x_slverr) begin
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
            state_d    = ST_RESP;
          end else if (x_rdata[SR_SPIF]) begin
            state_d = ST_RD_DR;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc >= LIMIT) begin
              rsp_err_d  = 1'b1;
              rsp_data_d = '0;
              state_d    = ST_RESP;
            end
          end
        end
`endif
      end
      ST_RD_DR: begin
        req      = 1'b1;
        req_addr = ADDR_DR;
        if (x_done) begin
          rsp_err_d  = x_slverr;
          rsp_data_d = x_slverr ? 8'h00 : x_rdata;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_READY;
      default: state_d = ST_IDLE;
    endcase
    rdy_d       = (state_d == ST_READY);
    busy_d      = (state_d != ST_IDLE) && (state_d != ST_READY);
    rsp_valid_d = (state_d == ST_RESP);
  end

  // Sequencer state, captured configuration and registered outputs.
  always_ff @(posedge P_clk or negedge P_rst) begin
    if (!P_rst) begin
      state_q     <= ST_IDLE;
      cr1_q       <= '0;
      cr2_q       <= '0;
      br_q        <= '0;
      cmd_q       <= '0;
      cnt_q       <= '0;
      cfg_done_q  <= 1'b0;
      rdy_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
`ifdef SPI_SEQ_IRQ_WAIT_EN
      irq_rd_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cr1_q       <= cr1_d;
      cr2_q       <= cr2_d;
      br_q        <= br_d;
      cmd_q       <= cmd_d;
      cnt_q       <= cnt_d;
      cfg_done_q  <= cfg_done_d;
      rdy_q       <= rdy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
`ifdef SPI_SEQ_IRQ_WAIT_EN
      irq_rd_q    <= irq_rd_d;
`endif
    end
  end

  spi_apb_seq_xfer u_xfer (
    .clk      (P_clk),
    .rst_n    (P_rst),
    .start    (req),
    .addr     (req_addr),
    .write    (req_write),
    .wdata    (req_wdata),
    .done     (x_done),
    .rdata    (x_rdata),
    .slverr   (x_slverr),
    .P_addr   (P_addr),
    .P_sel    (P_sel),
    .P_enable (P_enable),
    .P_write  (P_write),
    .P_wdata  (P_wdata),
    .P_ready  (P_ready),
    .P_slverr (P_slverr),
    .P_rdata  (P_rdata)
  );

  // cfg_start wins over a simultaneous command, so the handshake drops with it.
  assign cmd_ready = rdy_q & ~cfg_start;
  assign cfg_done  = cfg_done_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_spi_apb_seq.sv
// Self-checking bench for spi_apb_seq: APB slave model with a transaction
// scoreboard, response scoreboard and per-scenario latency checks.
module tb_spi_apb_seq;

  logic       P_clk = 1'b0;
  logic       P_rst = 1'b0;
  logic [2:0] P_addr;
  logic       P_sel, P_enable, P_write;
  logic [7:0] P_wdata;
  logic       P_ready = 1'b0;
  logic       P_slverr = 1'b0;
  logic [7:0] P_rdata = 8'h00;
  logic       spi_interrupt_request = 1'b0;
  logic [7:0] cfg_cr1 = 8'h00, cfg_cr2 = 8'h00, cfg_br = 8'h00;
  logic       cfg_start = 1'b0;
  logic       cfg_done;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_data = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       busy;

  always #5 P_clk = ~P_clk;

  spi_apb_seq #(.POLL_LIMIT(4)) dut (
    .P_clk(P_clk), .P_rst(P_rst), .P_addr(P_addr), .P_sel(P_sel),
    .P_enable(P_enable), .P_write(P_write), .P_wdata(P_wdata),
    .P_ready(P_ready), .P_slverr(P_slverr), .P_rdata(P_rdata),
    .spi_interrupt_request(spi_interrupt_request),
    .cfg_cr1(cfg_cr1), .cfg_cr2(cfg_cr2), .cfg_br(cfg_br),
    .cfg_start(cfg_start), .cfg_done(cfg_done),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy)
  );

  typedef struct { logic [2:0] addr; logic wr; logic [7:0] data; } apb_t;
  typedef struct { logic [7:0] data; logic err; } rsp_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  apb_t        apb_exp[$];
  rsp_t        rsp_exp[$];
  logic [7:0]  sr_q[$];
  logic [7:0]  dr_val = 8'h00;
  bit          slverr_dr_wr = 1'b0;
  int unsigned waits = 1;
  int unsigned acc_cnt = 0;
  int unsigned rsp_seen = 0;
  logic [2:0]  hold_addr;
  logic [7:0]  hold_data;
  logic        hold_wr;
  apb_t        cur_txn;
  rsp_t        cur_rsp;

  // APB slave model: configurable wait states, SR/DR read data, transaction scoreboard.
  always @(negedge P_clk) begin
    if (P_sel && !P_enable) begin
      hold_addr = P_addr;
      hold_data = P_wdata;
      hold_wr   = P_write;
      acc_cnt   = 0;
      P_ready   = 1'b0;
      P_slverr  = 1'b0;
      P_rdata   = 8'($urandom);
    end else if (P_sel && P_enable) begin
      n_cmp++;
      if (P_addr !== hold_addr || P_wdata !== hold_data || P_write !== hold_wr) begin
        n_bad++;
        $display("FAIL apb_stable: addr=%0d wdata=%02h write=%0b, required addr=%0d wdata=%02h write=%0b",
                 P_addr, P_wdata, P_write, hold_addr, hold_data, hold_wr);
      end
      if (acc_cnt == waits) begin
        P_ready  = 1'b1;
        P_slverr = 1'b0;
        P_rdata  = 8'h00;
        if (!P_write && P_addr == 3'd3) P_rdata = (sr_q.size() > 0) ? sr_q.pop_front() : 8'h20;
        else if (!P_write && P_addr == 3'd5) P_rdata = dr_val;
        else if (P_write && P_addr == 3'd5) P_slverr = slverr_dr_wr;
        n_cmp++;
        if (apb_exp.size() == 0) begin
          n_bad++;
          $display("FAIL apb_txn: got unexpected addr=%0d write=%0b wdata=%02h, required no transfer",
                   P_addr, P_write, P_wdata);
        end else begin
          cur_txn = apb_exp.pop_front();
          if (P_addr !== cur_txn.addr || P_write !== cur_txn.wr ||
              (cur_txn.wr && P_wdata !== cur_txn.data)) begin
            n_bad++;
            $display("FAIL apb_txn: got addr=%0d write=%0b wdata=%02h, required addr=%0d write=%0b wdata=%02h",
                     P_addr, P_write, P_wdata, cur_txn.addr, cur_txn.wr, cur_txn.data);
          end
        end
      end else begin
        P_ready  = 1'b0;
        P_slverr = 1'b0;
        P_rdata  = 8'($urandom);
      end
      acc_cnt++;
    end else begin
      P_ready  = 1'b0;
      P_slverr = 1'b0;
      acc_cnt  = 0;
    end
  end

  // Response scoreboard.
  always @(negedge P_clk) begin
    if (P_rst && rsp_valid) begin
      rsp_seen++;
      n_cmp++;
      if (rsp_exp.size() == 0) begin
        n_bad++;
        $display("FAIL rsp: got unexpected data=%02h err=%0b, required no response", rsp_data, rsp_err);
      end else begin
        cur_rsp = rsp_exp.pop_front();
        if (rsp_data !== cur_rsp.data || rsp_err !== cur_rsp.err) begin
          n_bad++;
          $display("FAIL rsp: got data=%02h err=%0b, required data=%02h err=%0b",
                   rsp_data, rsp_err, cur_rsp.data, cur_rsp.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic drive_cfg(input logic [7:0] c2, input logic [7:0] b, input logic [7:0] c1,
                           output int unsigned lat);
    @(negedge P_clk);
    cfg_cr2 = c2; cfg_br = b; cfg_cr1 = c1; cfg_start = 1'b1;
    @(posedge P_clk); #1;
    cfg_start = 1'b0;
    cfg_cr2 = 8'hFF; cfg_br = 8'hFF; cfg_cr1 = 8'hFF;
    lat = 1;
    while (!cfg_done && lat < 100) begin @(posedge P_clk); #1; lat++; end
  endtask

  task automatic drive_cmd(input logic [7:0] b, output int unsigned lat, output logic rdy);
    @(negedge P_clk);
    cmd_data = b; cmd_valid = 1'b1;
    #1 rdy = cmd_ready;
    @(posedge P_clk); #1;
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 200) begin @(posedge P_clk); #1; lat++; end
    @(negedge P_clk); #1;
  endtask

  task automatic test_reset;
    P_rst = 1'b0;
    repeat (3) @(posedge P_clk);
    #1;
    n_cmp++;
    if ({P_sel, P_enable, P_write, P_addr, P_wdata} !== 14'h0) begin
      n_bad++;
      $display("FAIL reset_apb: got %h, required 0", {P_sel, P_enable, P_write, P_addr, P_wdata});
    end
    n_cmp++;
    if ({cfg_done, cmd_ready, rsp_valid, rsp_err, rsp_data, busy} !== 13'h0) begin
      n_bad++;
      $display("FAIL reset_out: got %h, required 0", {cfg_done, cmd_ready, rsp_valid, rsp_err, rsp_data, busy});
    end
    @(negedge P_clk) P_rst = 1'b1;
    repeat (2) @(posedge P_clk);
    #1;
    n_cmp++;
    if ({cmd_ready, busy, P_sel} !== 3'b000) begin
      n_bad++;
      $display("FAIL idle_after_reset: got %b, required 000", {cmd_ready, busy, P_sel});
    end
  endtask

  task automatic test_config;
    int unsigned lat;
    apb_exp.push_back('{3'd1, 1'b1, 8'h02});
    apb_exp.push_back('{3'd2, 1'b1, 8'h23});
    apb_exp.push_back('{3'd0, 1'b1, 8'h50});
    drive_cfg(8'h02, 8'h23, 8'h50, lat);
    n_cmp++;
    if (lat !== 13) begin n_bad++; $display("FAIL cfg_latency: got %0d, required 13", lat); end
    n_cmp++;
    if ({cmd_ready, busy} !== 2'b10) begin
      n_bad++; $display("FAIL cfg_ready: got cmd_ready,busy=%b, required 10", {cmd_ready, busy});
    end
    n_cmp++;
    if (apb_exp.size() != 0) begin n_bad++; $display("FAIL cfg_writes: %0d missing, required 0", apb_exp.size()); end
  endtask

  task automatic test_cmd_poll;
    int unsigned lat; logic rdy;
    sr_q = '{8'h20, 8'h20, 8'hA0};
    dr_val = 8'h3C;
    apb_exp.push_back('{3'd5, 1'b1, 8'hA5});
    repeat (3) apb_exp.push_back('{3'd3, 1'b0, 8'h00});
    apb_exp.push_back('{3'd5, 1'b0, 8'h00});
    rsp_exp.push_back('{8'h3C, 1'b0});
    drive_cmd(8'hA5, lat, rdy);
    n_cmp++;
    if (rdy !== 1'b1) begin n_bad++; $display("FAIL cmd_ready: got %b, required 1", rdy); end
    n_cmp++;
    if (lat !== 21) begin n_bad++; $display("FAIL poll_latency: got %0d, required 21", lat); end
    n_cmp++;
    if (apb_exp.size() + rsp_exp.size() != 0) begin
      n_bad++; $display("FAIL poll_pending: got %0d outstanding, required 0", apb_exp.size() + rsp_exp.size());
    end
  endtask

  task automatic test_slverr;
    int unsigned lat; logic rdy;
    slverr_dr_wr = 1'b1;
    apb_exp.push_back('{3'd5, 1'b1, 8'h96});
    rsp_exp.push_back('{8'h00, 1'b1});
    drive_cmd(8'h96, lat, rdy);
    slverr_dr_wr = 1'b0;
    n_cmp++;
    if (lat !== 5) begin n_bad++; $display("FAIL slverr_latency: got %0d, required 5", lat); end
    n_cmp++;
    if (apb_exp.size() + rsp_exp.size() != 0) begin
      n_bad++; $display("FAIL slverr_pending: got %0d outstanding, required 0", apb_exp.size() + rsp_exp.size());
    end
  endtask

  task automatic test_wait_states;
    int unsigned lat; logic rdy;
    waits = 3;
    sr_q = '{8'h80};
    dr_val = 8'hC3;
    apb_exp.push_back('{3'd5, 1'b1, 8'h5A});
    apb_exp.push_back('{3'd3, 1'b0, 8'h00});
    apb_exp.push_back('{3'd5, 1'b0, 8'h00});
    rsp_exp.push_back('{8'hC3, 1'b0});
    drive_cmd(8'h5A, lat, rdy);
    waits = 1;
    n_cmp++;
    if (lat !== 19) begin n_bad++; $display("FAIL wait_latency: got %0d, required 19", lat); end
    n_cmp++;
    if (apb_exp.size() + rsp_exp.size() != 0) begin
      n_bad++; $display("FAIL wait_pending: got %0d outstanding, required 0", apb_exp.size() + rsp_exp.size());
    end
  endtask

  task automatic test_timeout;
    int unsigned lat; logic rdy;
    sr_q.delete();
    apb_exp.push_back('{3'd5, 1'b1, 8'h33});
    repeat (4) apb_exp.push_back('{3'd3, 1'b0, 8'h00});
    rsp_exp.push_back('{8'h00, 1'b1});
    drive_cmd(8'h33, lat, rdy);
    n_cmp++;
    if (lat !== 21) begin n_bad++; $display("FAIL timeout_latency: got %0d, required 21", lat); end
    repeat (5) @(posedge P_clk);
    n_cmp++;
    if (apb_exp.size() + rsp_exp.size() != 0) begin
      n_bad++; $display("FAIL timeout_pending: got %0d outstanding, required 0", apb_exp.size() + rsp_exp.size());
    end
  endtask

  task automatic test_cfg_priority;
    int unsigned lat; int unsigned seen0;
    seen0 = rsp_seen;
    apb_exp.push_back('{3'd1, 1'b1, 8'h00});
    apb_exp.push_back('{3'd2, 1'b1, 8'h07});
    apb_exp.push_back('{3'd0, 1'b1, 8'h50});
    @(negedge P_clk);
    cfg_cr2 = 8'h00; cfg_br = 8'h07; cfg_cr1 = 8'h50;
    cfg_start = 1'b1; cmd_valid = 1'b1; cmd_data = 8'h11;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL prio_cmd_ready: got %b, required 0", cmd_ready); end
    @(posedge P_clk); #1;
    cfg_start = 1'b0; cmd_valid = 1'b0;
    cfg_cr2 = 8'hFF; cfg_br = 8'hFF; cfg_cr1 = 8'hFF;
    n_cmp++;
    if ({cfg_done, busy} !== 2'b01) begin
      n_bad++; $display("FAIL prio_reprogram: got cfg_done,busy=%b, required 01", {cfg_done, busy});
    end
    lat = 1;
    while (!cfg_done && lat < 100) begin @(posedge P_clk); #1; lat++; end
    n_cmp++;
    if (lat !== 13) begin n_bad++; $display("FAIL prio_cfg_latency: got %0d, required 13", lat); end
    repeat (3) @(posedge P_clk);
    n_cmp++;
    if (rsp_seen != seen0 || apb_exp.size() != 0) begin
      n_bad++; $display("FAIL prio_no_cmd: got %0d responses %0d pending, required 0 and 0",
                        rsp_seen - seen0, apb_exp.size());
    end
  endtask

  task automatic test_reset_mid;
    int unsigned n; int unsigned seen0;
    sr_q.delete();
    apb_exp.push_back('{3'd5, 1'b1, 8'h77});
    apb_exp.push_back('{3'd3, 1'b0, 8'h00});
    @(negedge P_clk);
    cmd_data = 8'h77; cmd_valid = 1'b1;
    @(posedge P_clk); #1;
    cmd_valid = 1'b0;
    n = 0;
    while (!(P_sel && P_addr == 3'd3) && n < 50) begin @(negedge P_clk); n++; end
    n_cmp++;
    if (n >= 50) begin n_bad++; $display("FAIL mid_reach_poll: got no SR access, required one"); end
    #2 P_rst = 1'b0;
    #1;
    n_cmp++;
    if ({P_sel, P_enable, busy, cfg_done} !== 4'b0000) begin
      n_bad++; $display("FAIL mid_reset_drop: got sel,en,busy,cfg_done=%b, required 0000",
                        {P_sel, P_enable, busy, cfg_done});
    end
    n_cmp++;
    if (apb_exp.size() != 1) begin n_bad++; $display("FAIL mid_pending: got %0d, required 1", apb_exp.size()); end
    apb_exp.delete();
    repeat (2) @(posedge P_clk);
    @(negedge P_clk) P_rst = 1'b1;
    seen0 = rsp_seen;
    repeat (30) @(posedge P_clk);
    #1;
    n_cmp++;
    if (rsp_seen != seen0 || P_sel !== 1'b0) begin
      n_bad++; $display("FAIL mid_no_rsp: got %0d responses sel=%b, required 0 responses sel=0",
                        rsp_seen - seen0, P_sel);
    end
  endtask

  initial begin
    test_reset();
    test_config();
    test_cmd_poll();
    test_slverr();
    test_wait_states();
    test_timeout();
    test_cfg_priority();
    test_reset_mid();
    n_cmp++;
    if (rsp_exp.size() != 0) begin n_bad++; $display("FAIL final_rsp_queue: got %0d, required 0", rsp_exp.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
